// File: rtl/rxheaderbitp_pkg.sv
// Shared constants, state encoding and helpers for the RX access-code/header path.
// Field offsets and polynomials match the TX serializer.
package rxheaderbitp_pkg;

   localparam int TRAILER_LEN   = 4;
   localparam int HDR_TRIPLETS  = 18;
   localparam int HDR_FIELD_LEN = 10;
   localparam int HDR_BITS      = 3 * HDR_TRIPLETS;
   localparam int EDR_GUARD_LEN = 5;
   localparam int EDR_SYNC_LEN  = 11;

   localparam logic [7:0] HEC_POLY    = 8'hA7;
   localparam logic [6:0] WHITEN_TAPS = 7'h11;

   localparam int LT_ADDR_OFS = 0;
   localparam int TYPE_OFS    = 3;
   localparam int FLOW_OFS    = 7;
   localparam int ARQN_OFS    = 8;
   localparam int SEQN_OFS    = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRAILER,
      ST_HEADER,
      ST_GUARD,
      ST_EDRSYNC
   } rx_state_e;

   function automatic logic [6:0] whiten_next(input logic [6:0] w);
      return {w[5:0], 1'b0} ^ ({7{w[6]}} & WHITEN_TAPS);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_hec_lfsr.sv
// Serial 8-bit HEC checker: seeded with the UAP, fed header bits then check bits
// MSB-first; a good header leaves the register at zero.
module rx_hec_lfsr
   import rxheaderbitp_pkg::*;
(
   input  logic       clk_6M,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       shift,
   input  logic       din,
   output logic       zero
);

   logic [7:0] rem;

   always_ff @(posedge clk_6M) begin
      if (rst) begin
         rem <= '0;
      end else if (load) begin
         rem <= seed;
      end else if (shift) begin
         rem <= {rem[6:0], 1'b0} ^ ({8{rem[7] ^ din}} & HEC_POLY);
      end
   end

   assign zero = (rem == 8'h00);

endmodule

// File: rtl/rxheaderbitp.sv
// RX trailer/header decoder: FEC-1/3 majority vote, de-whitening, HEC check,
// field latch and BR/EDR payload start strobes.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for sync_found_p
// ST_TRAILER | skipping the trailer bits
// ST_HEADER  | collecting 54 header bits, then one cycle for the HEC verdict
// ST_GUARD   | EDR guard time
// ST_EDRSYNC | EDR sync sequence, py_st_p at its end
module rxheaderbitp
   import rxheaderbitp_pkg::*;
(
   input  logic        clk_6M,
   input  logic        rst,
   input  logic        p_1us,
   input  logic        rxbit,
   input  logic        sync_found_p,
   input  logic        idpkt,
   input  logic        rx_abort,
   input  logic        packet_BRmode,
   input  logic        regi_rxwhitening,
   input  logic [7:0]  regi_hec_UAP,
   input  logic [27:0] CLK,
   input  logic [2:0]  regi_LT_ADDR,
   output logic        id_rcv_p,
   output logic        header_period,
   output logic        header_ok_p,
   output logic        header_err_p,
   output logic        lt_addr_match,
   output logic [2:0]  rx_LT_ADDR,
   output logic [3:0]  rx_packet_type,
   output logic        rx_FLOW,
   output logic        rx_ARQN,
   output logic        rx_SEQN,
   output logic        guard_st_p,
   output logic        edrsync11_st_p,
   output logic        py_st_p,
   output logic [6:0]  whitening
);

   rx_state_e    state;
   logic [5:0]   bitcnt;
   logic [1:0]   phase;
   logic [4:0]   trip;
   logic [3:0]   tmr;
   logic [1:0]   b_hist;
   logic [9:0]   field_sr;
   logic         hdr_done;
   logic         hdr_bit;
   logic         hec_load;
   logic         hec_shift;
   logic         hec_zero;
   logic         unused_clk;

   assign unused_clk = ^{CLK[27:7], CLK[0]};

   assign hdr_bit   = maj3(b_hist[0], b_hist[1], rxbit) ^ (regi_rxwhitening & whitening[6]);
   assign hec_load  = !rx_abort && (state == ST_IDLE) && p_1us && sync_found_p && !idpkt;
   assign hec_shift = !rx_abort && (state == ST_HEADER) && !hdr_done && p_1us && (phase == 2'd2);

   rx_hec_lfsr u_hec (
      .clk_6M (clk_6M),
      .rst    (rst),
      .load   (hec_load),
      .seed   (regi_hec_UAP),
      .shift  (hec_shift),
      .din    (hdr_bit),
      .zero   (hec_zero)
   );

   always_ff @(posedge clk_6M) begin
      if (rst) begin
         state          <= ST_IDLE;
         bitcnt         <= '0;
         phase          <= '0;
         trip           <= '0;
         tmr            <= '0;
         b_hist         <= '0;
         field_sr       <= '0;
         hdr_done       <= 1'b0;
         whitening      <= '0;
         id_rcv_p       <= 1'b0;
         header_period  <= 1'b0;
         header_ok_p    <= 1'b0;
         header_err_p   <= 1'b0;
         lt_addr_match  <= 1'b0;
         rx_LT_ADDR     <= '0;
         rx_packet_type <= '0;
         rx_FLOW        <= 1'b0;
         rx_ARQN        <= 1'b0;
         rx_SEQN        <= 1'b0;
         guard_st_p     <= 1'b0;
         edrsync11_st_p <= 1'b0;
         py_st_p        <= 1'b0;
      end else begin
         id_rcv_p       <= 1'b0;
         header_ok_p    <= 1'b0;
         header_err_p   <= 1'b0;
         guard_st_p     <= 1'b0;
         edrsync11_st_p <= 1'b0;
         py_st_p        <= 1'b0;

         if (rx_abort) begin
            state         <= ST_IDLE;
            header_period <= 1'b0;
            hdr_done      <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (p_1us && sync_found_p) begin
                     if (idpkt) begin
                        id_rcv_p <= 1'b1;
                     end else begin
                        state         <= ST_TRAILER;
                        bitcnt        <= '0;
                        phase         <= '0;
                        trip          <= '0;
                        tmr           <= 4'(TRAILER_LEN - 1);
                        header_period <= 1'b1;
                        whitening     <= {1'b1, CLK[6:1]};
                     end
                  end
               end

               ST_TRAILER: begin
                  if (p_1us) begin
                     if (tmr == 4'd0) state <= ST_HEADER;
                     else             tmr   <= tmr - 4'd1;
                  end
               end

               ST_HEADER: begin
                  // Verdict cycle: the HEC register has absorbed the last check bit.
                  if (hdr_done) begin
                     hdr_done <= 1'b0;
                     if (hec_zero) begin
                        header_ok_p    <= 1'b1;
                        rx_LT_ADDR     <= field_sr[LT_ADDR_OFS +: 3];
                        rx_packet_type <= field_sr[TYPE_OFS +: 4];
                        rx_FLOW        <= field_sr[FLOW_OFS];
                        rx_ARQN        <= field_sr[ARQN_OFS];
                        rx_SEQN        <= field_sr[SEQN_OFS];
                        lt_addr_match  <= (field_sr[LT_ADDR_OFS +: 3] == regi_LT_ADDR);
                        if (packet_BRmode) begin
                           py_st_p <= 1'b1;
                           state   <= ST_IDLE;
                        end else begin
                           guard_st_p <= 1'b1;
                           tmr        <= 4'(EDR_GUARD_LEN - 1);
                           state      <= ST_GUARD;
                        end
                     end else begin
                        header_err_p <= 1'b1;
                        state        <= ST_IDLE;
                     end
                  end else if (p_1us) begin
                     bitcnt <= bitcnt + 6'd1;
                     if (phase == 2'd2) begin
                        phase     <= '0;
                        trip      <= trip + 5'd1;
                        whitening <= whiten_next(whitening);
                        if (trip < 5'(HDR_FIELD_LEN)) field_sr <= {hdr_bit, field_sr[9:1]};
                     end else begin
                        b_hist[phase[0]] <= rxbit;
                        phase            <= phase + 2'd1;
                     end
                     if (bitcnt == 6'(HDR_BITS - 1)) begin
                        hdr_done      <= 1'b1;
                        header_period <= 1'b0;
                     end
                  end
               end

               ST_GUARD: begin
                  if (p_1us) begin
                     if (tmr == 4'd0) begin
                        edrsync11_st_p <= 1'b1;
                        tmr            <= 4'(EDR_SYNC_LEN - 1);
                        state          <= ST_EDRSYNC;
                     end else begin
                        tmr <= tmr - 4'd1;
                     end
                  end
               end

               ST_EDRSYNC: begin
                  if (p_1us) begin
                     if (tmr == 4'd0) begin
                        py_st_p <= 1'b1;
                        state   <= ST_IDLE;
                     end else begin
                        tmr <= tmr - 4'd1;
                     end
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
